// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: sync, 11-bit frame FSM with watchdog, E0/F0 prefix decode, FWFT event FIFO.
// Latency: stop edge seen in cycle N -> error pulse / FIFO push in N+1, ev_valid from N+2.
// Backpressure: ev_ready stalls the FIFO head; when full without a pop, new events are dropped and overflow latches.
module ps2_kbd_rx #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_break,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   clk_prev_q;
  logic                   fall, bit_in;

  state_t      state_q, state_d;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic        par_q;
  logic [WDW-1:0] wd_q;
  logic        timeout;
  logic        par_err_q, par_err_d;
  logic        frm_err_q, frm_err_d;
  logic        byte_vld_q, byte_vld_d;

  logic        ext_pend_q, brk_pend_q;
  logic        is_prefix, push_req, do_push, do_pop, drop, full;
  logic [9:0]  push_dat, head, last_q;
  logic [9:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic        ovf_q;

  // Synchronise both PS/2 lines; idle-high reset avoids a false edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign fall    = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign bit_in  = dat_sync_q[SYNC_STAGES-1];
  assign timeout = (state_q != S_IDLE) && !fall && (wd_q == WDW'(TIMEOUT_CYCLES - 1));

  // Frame FSM next state and one-cycle result strobes (registered below).
  always_comb begin
    state_d    = state_q;
    par_err_d  = 1'b0;
    frm_err_d  = 1'b0;
    byte_vld_d = 1'b0;
    if (timeout) begin
      state_d   = S_IDLE;
      frm_err_d = 1'b1;
    end else if (fall) begin
      case (state_q)
        S_IDLE:   if (!bit_in) state_d = S_DATA; else frm_err_d = 1'b1;
        S_DATA:   if (bit_idx_q == 3'd7) state_d = S_PARITY;
        S_PARITY: state_d = S_STOP;
        S_STOP: begin
          state_d = S_IDLE;
          // A bad stop bit outranks a parity failure.
          if (!bit_in)                 frm_err_d  = 1'b1;
          else if (!(^{shift_q, par_q})) par_err_d = 1'b1;
          else                         byte_vld_d = 1'b1;
        end
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // FSM state and strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      byte_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      byte_vld_q <= byte_vld_d;
    end
  end

  // Frame datapath: bit counter, LSB-first shift register, parity bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
    end else if (fall && !timeout) begin
      case (state_q)
        S_IDLE:   bit_idx_q <= '0;
        S_DATA: begin
          shift_q   <= {bit_in, shift_q[7:1]};
          bit_idx_q <= bit_idx_q + 3'd1;
        end
        S_PARITY: par_q <= bit_in;
        default:  ;
      endcase
    end
  end

  // Watchdog: cycles since the last falling edge while a frame is open.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    wd_q <= '0;
    else if (state_q == S_IDLE || fall || timeout) wd_q <= '0;
    else                                        wd_q <= wd_q + 1'b1;
  end

  assign is_prefix = (shift_q == 8'hE0) || (shift_q == 8'hF0);
  assign push_req  = byte_vld_q && !is_prefix;
  assign push_dat  = {ext_pend_q, brk_pend_q, shift_q};

  // Prefix flags: set by E0/F0, consumed by the next event, dropped on any error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
    end else if (par_err_q || frm_err_q) begin
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
    end else if (byte_vld_q) begin
      if (shift_q == 8'hE0)      ext_pend_q <= 1'b1;
      else if (shift_q == 8'hF0) brk_pend_q <= 1'b1;
      else begin
        ext_pend_q <= 1'b0;
        brk_pend_q <= 1'b0;
      end
    end
  end

  assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign do_pop  = ev_valid && ev_ready;
  assign do_push = push_req && (!full || do_pop);
  assign drop    = push_req && full && !do_pop;
  assign head    = mem_q[rd_ptr_q];

  // Event storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

  // FIFO pointers, occupancy, last-popped holding register and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= head;
      end
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign ev_valid   = (count_q != '0);
  assign {ev_ext, ev_break, ev_code} = ev_valid ? head : last_q;
  assign fifo_count = count_q;
  assign parity_err = par_err_q;
  assign frame_err  = frm_err_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Bench for ps2_kbd_rx: bit-banged PS/2 frames, event/pulse monitor, prefix-rule reference model.
module tb_ps2_kbd_rx;
  localparam int T    = 40;
  localparam int D    = 8;
  localparam int S    = 2;
  localparam int HALF = 4;

  logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1, ev_ready = 1'b0, ovf_clr = 1'b0;
  logic ev_valid, ev_ext, ev_break, parity_err, frame_err, overflow;
  logic [7:0] ev_code;
  logic [$clog2(D):0] fifo_count;

  ps2_kbd_rx #(.TIMEOUT_CYCLES(T), .FIFO_DEPTH(D), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext),
    .ev_break(ev_break), .fifo_count(fifo_count), .parity_err(parity_err),
    .frame_err(frame_err), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;

  // Monitor: popped events, pulse counts and cycle stamps.
  logic [9:0] got_q[$];
  int par_cnt = 0, frm_cnt = 0, par_cyc = -1, frm_cyc = -1, rise_cyc = -1;
  logic prev_vld = 1'b0;
  always @(negedge clk) begin
    if (rst) prev_vld = 1'b0;
    else begin
      if (ev_valid && !prev_vld) rise_cyc = cyc;
      prev_vld = ev_valid;
      if (ev_valid && ev_ready) got_q.push_back({ev_ext, ev_break, ev_code});
      if (parity_err) begin par_cnt++; par_cyc = cyc; end
      if (frame_err)  begin frm_cnt++; frm_cyc = cyc; end
    end
  end

  // Reference model: prefix rules applied to the sequence of received bytes.
  logic [9:0] exp_q[$];
  logic m_ext = 1'b0, m_brk = 1'b0;
  int exp_par = 0, exp_frm = 0;
  task automatic model_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    if (bad_stop)      begin exp_frm++; m_ext = 0; m_brk = 0; end
    else if (bad_par)  begin exp_par++; m_ext = 0; m_brk = 0; end
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin exp_q.push_back({m_ext, m_brk, b}); m_ext = 0; m_brk = 0; end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n, output int last_cyc);
    last_cyc = -1;
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      step(HALF);
      ps2_clk = 1'b0;
      last_cyc = cyc;
      step(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, output int stop_cyc);
    logic p;
    p = (~^b) ^ bad_par;
    send_bits({~bad_stop, p, b, 1'b0}, 11, stop_cyc);
    ps2_data = 1'b1;
    step(4 * HALF);
  endtask

  task automatic test_reset();
    step(3);
    tests++;
    if ({ev_valid, ev_ext, ev_break, parity_err, frame_err, overflow} !== 6'b0) begin
      fails++; $display("FAIL reset_flags: got %b expected 000000",
                        {ev_valid, ev_ext, ev_break, parity_err, frame_err, overflow});
    end
    tests++;
    if (ev_code !== 8'h00 || fifo_count !== '0) begin
      fails++; $display("FAIL reset_data: code %h count %0d expected 00/0", ev_code, fifo_count);
    end
    rst = 1'b0;
    step(4);
  endtask

  task automatic test_make_1c();
    int sc, p0, f0;
    ev_ready = 1'b1; got_q.delete(); exp_q.delete(); rise_cyc = -1;
    p0 = par_cnt; f0 = frm_cnt;
    model_byte(8'h1C, 0, 0);
    send_frame(8'h1C, 0, 0, sc);
    step(4);
    tests++;
    if (got_q.size() != 1 || got_q[0] !== 10'h01C) begin
      fails++; $display("FAIL make_1c_event: got %0d events first %h expected 1 event 01c",
                        got_q.size(), (got_q.size() > 0) ? got_q[0] : 10'h3FF);
    end
    tests++;
    if (rise_cyc != sc + S + 2) begin
      fails++; $display("FAIL make_1c_latency: valid at cycle %0d expected %0d", rise_cyc, sc + S + 2);
    end
    tests++;
    if (par_cnt != p0 || frm_cnt != f0) begin
      fails++; $display("FAIL make_1c_noerr: pulses par %0d frm %0d expected 0/0", par_cnt - p0, frm_cnt - f0);
    end
    tests++;
    if (ev_valid !== 1'b0 || ev_code !== 8'h1C) begin
      fails++; $display("FAIL make_1c_retain: valid %b code %h expected 0/1c", ev_valid, ev_code);
    end
  endtask

  task automatic test_prefix();
    int sc;
    logic [7:0] seq [7] = '{8'hF0, 8'h1C, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    logic [9:0] want [3] = '{10'h11C, 10'h275, 10'h375};
    got_q.delete();
    foreach (seq[i]) send_frame(seq[i], 0, 0, sc);
    step(4);
    tests++;
    if (got_q.size() != 3) begin
      fails++; $display("FAIL prefix_count: got %0d events expected 3", got_q.size());
    end else begin
      foreach (want[i]) begin
        tests++;
        if (got_q[i] !== want[i]) begin
          fails++; $display("FAIL prefix_event%0d: got %h expected %h", i, got_q[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_parity();
    int sc, p0, f0;
    got_q.delete();
    p0 = par_cnt; f0 = frm_cnt;
    send_frame(8'hE0, 0, 0, sc);
    send_frame(8'h1C, 1, 0, sc);
    tests++;
    if (par_cnt != p0 + 1 || frm_cnt != f0 || par_cyc != sc + S + 1) begin
      fails++; $display("FAIL parity_pulse: par %0d frm %0d at cycle %0d expected 1/0 at %0d",
                        par_cnt - p0, frm_cnt - f0, par_cyc, sc + S + 1);
    end
    tests++;
    if (got_q.size() != 0) begin
      fails++; $display("FAIL parity_noevent: got %0d events expected 0", got_q.size());
    end
    send_frame(8'h1C, 0, 0, sc);
    step(4);
    tests++;
    if (got_q.size() != 1 || got_q[0] !== 10'h01C) begin
      fails++; $display("FAIL parity_clears_ext: got %0d events first %h expected 01c",
                        got_q.size(), (got_q.size() > 0) ? got_q[0] : 10'h3FF);
    end
  endtask

  task automatic test_watchdog();
    int lc, sc, f0;
    got_q.delete();
    f0 = frm_cnt;
    send_bits(11'b000_0000_1010, 5, lc);
    ps2_data = 1'b1;
    step(T + S + 10);
    tests++;
    if (frm_cnt != f0 + 1 || frm_cyc != lc + S + 1 + T) begin
      fails++; $display("FAIL watchdog_timeout: pulses %0d at cycle %0d expected 1 at %0d",
                        frm_cnt - f0, frm_cyc, lc + S + 1 + T);
    end
    send_frame(8'h29, 0, 0, sc);
    step(4);
    tests++;
    if (got_q.size() != 1 || got_q[0] !== 10'h029) begin
      fails++; $display("FAIL watchdog_recover: got %0d events first %h expected 029",
                        got_q.size(), (got_q.size() > 0) ? got_q[0] : 10'h3FF);
    end
  endtask

  task automatic test_overflow();
    int sc;
    ev_ready = 1'b0; got_q.delete();
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, sc);
    tests++;
    if (fifo_count !== 4'd8 || overflow !== 1'b1 || ev_valid !== 1'b1 || ev_code !== 8'h01) begin
      fails++; $display("FAIL ovf_full: count %0d ovf %b valid %b head %h expected 8/1/1/01",
                        fifo_count, overflow, ev_valid, ev_code);
    end
    ev_ready = 1'b1;
    step(12);
    tests++;
    if (got_q.size() != 8) begin
      fails++; $display("FAIL ovf_drain_count: got %0d events expected 8", got_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests++;
        if (got_q[i] !== 10'(i + 1)) begin
          fails++; $display("FAIL ovf_order%0d: got %h expected %h", i, got_q[i], 10'(i + 1));
        end
      end
    end
    tests++;
    if (ev_valid !== 1'b0 || fifo_count !== '0 || overflow !== 1'b1) begin
      fails++; $display("FAIL ovf_empty: valid %b count %0d ovf %b expected 0/0/1", ev_valid, fifo_count, overflow);
    end
    ovf_clr = 1'b1; step(1); ovf_clr = 1'b0;
    tests++;
    if (overflow !== 1'b0) begin
      fails++; $display("FAIL ovf_clr: got %b expected 0", overflow);
    end
  endtask

  task automatic test_reset_mid();
    int sc;
    ev_ready = 1'b0; got_q.delete();
    send_frame(8'h1C, 0, 0, sc);
    send_frame(8'h29, 0, 0, sc);
    send_frame(8'h75, 0, 0, sc);
    tests++;
    if (fifo_count !== 4'd3) begin
      fails++; $display("FAIL rstmid_queued: count %0d expected 3", fifo_count);
    end
    send_bits(11'b000_0000_0110, 3, sc);
    #1 rst = 1'b1;
    #1;
    tests++;
    if ({ev_valid, ev_ext, ev_break, parity_err, frame_err, overflow} !== 6'b0 ||
        ev_code !== 8'h00 || fifo_count !== '0) begin
      fails++; $display("FAIL rstmid_outputs: flags %b code %h count %0d expected all 0",
                        {ev_valid, ev_ext, ev_break, parity_err, frame_err, overflow}, ev_code, fifo_count);
    end
    step(2);
    rst = 1'b0; ps2_data = 1'b1;
    m_ext = 0; m_brk = 0;
    step(3);
    ev_ready = 1'b1; got_q.delete();
    send_frame(8'h1C, 0, 0, sc);
    step(4);
    tests++;
    if (got_q.size() != 1 || got_q[0] !== 10'h01C) begin
      fails++; $display("FAIL rstmid_after: got %0d events first %h expected 01c",
                        got_q.size(), (got_q.size() > 0) ? got_q[0] : 10'h3FF);
    end
  endtask

  task automatic test_random();
    bit done = 0;
    int p0, f0;
    got_q.delete(); exp_q.delete(); m_ext = 0; m_brk = 0; exp_par = 0; exp_frm = 0;
    p0 = par_cnt; f0 = frm_cnt;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          int r, sc;
          logic [7:0] b;
          bit bp, bs;
          r = $urandom_range(0, 99);
          b = 8'($urandom);
          bp = 0; bs = 0;
          if (r < 15)      b = 8'hE0;
          else if (r < 30) b = 8'hF0;
          else if (r < 38) bp = 1;
          else if (r < 44) bs = 1;
          else if (r < 48) begin bp = 1; bs = 1; end
          model_byte(b, bp, bs);
          send_frame(b, bp, bs, sc);
        end
        done = 1;
      end
      begin
        while (!done) begin
          ev_ready = 1'($urandom_range(0, 1));
          step(1);
        end
      end
    join
    ev_ready = 1'b1;
    step(20);
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL random_count: got %0d events expected %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests++;
        if (got_q[i] !== exp_q[i]) begin
          fails++; $display("FAIL random_event%0d: got %h expected %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    tests++;
    if (par_cnt - p0 != exp_par || frm_cnt - f0 != exp_frm || overflow !== 1'b0) begin
      fails++; $display("FAIL random_errors: par %0d frm %0d ovf %b expected %0d/%0d/0",
                        par_cnt - p0, frm_cnt - f0, overflow, exp_par, exp_frm);
    end
  endtask

  initial begin
    test_reset();
    test_make_1c();
    test_prefix();
    test_parity();
    test_watchdog();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL time_limit: simulation did not complete, expected completion before 2 ms");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
Parametrised PS/2 keyboard receiver. It is the next generation of our single-byte PS/2 scancode front end and sits between the PS/2 pins and game control logic.
- Adds start/parity/stop checking, a frame watchdog, and make/break plus extended-prefix decoding.
- Decoded key events are buffered in a FIFO with a valid/ready interface, so slow consumers do not lose keystrokes.

Parameters:
TIMEOUT_CYCLES, 50000, clk cycles without a PS/2 falling edge before a partial frame is aborted (1 ms at 50 MHz).
FIFO_DEPTH, 8, event FIFO entries; power of two, >= 2.
SYNC_STAGES, 2, synchroniser flops on ps2_clk and ps2_data; >= 2.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
ps2_clk  in  1  raw PS/2 clock, asynchronous
ps2_data  in  1  raw PS/2 data, asynchronous
ev_valid  out  1  FIFO head holds an event
ev_ready  in  1  consumer accepts head this cycle
ev_code  out  8  scancode of head event
ev_ext  out  1  head event was preceded by E0
ev_break  out  1  head event was preceded by F0 (key release)
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries
parity_err  out  1  one-cycle pulse: frame failed odd parity
frame_err  out  1  one-cycle pulse: bad start/stop bit or watchdog timeout
overflow  out  1  sticky: an event was dropped because the FIFO was full
ovf_clr  in  1  clears overflow

Behaviour:
- Reset values: all outputs 0, FIFO empty, FSM in IDLE, prefix flags cleared, watchdog 0.
- Synchronisation: both lines pass through SYNC_STAGES flops. A falling edge is detected when the previous synced clk is 1 and the current synced clk is 0; data is sampled from the synced data line in that cycle.
- Frame FSM, advancing on falling edges only:
  - IDLE: data=0 -> DATA, bit index 0. data=1 -> stay in IDLE and pulse frame_err.
  - DATA: shift LSB first; after the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: data=1 and odd parity (8 data bits + parity have an odd number of ones) -> byte complete. Parity wrong -> parity_err. Stop=0 -> frame_err; if both are wrong, only frame_err. Always return to IDLE.
- Watchdog:
  - Counts clk cycles while the FSM is not in IDLE and resets on every falling edge.
  - Reaching TIMEOUT_CYCLES forces IDLE and pulses frame_err.
  - While in IDLE it is held at 0.
- Prefix decoder, acting on completed good bytes:
  - E0 sets ext_pend; F0 sets brk_pend; neither pushes an event.
  - Any other byte pushes {ext_pend, brk_pend, byte}, then clears both flags.
  - Any parity_err or frame_err clears both flags.
  - Sequence E0 F0 xx yields ext=1, break=1.
- Latency:
  - Stop-bit edge detected in cycle N: push in cycle N+1, ev_valid=1 from cycle N+2 if the FIFO was empty.
  - Error pulses are asserted in cycle N+1.
- FIFO:
  - First-word-fall-through: ev_code, ev_ext and ev_break reflect the head whenever ev_valid=1. They retain their last value when the FIFO is empty; after reset they are 0.
  - Pop when ev_valid && ev_ready.
  - Push when full without a simultaneous pop: event dropped, overflow set.
  - Push when full with a simultaneous pop: both succeed and the count is unchanged.
  - Push and pop on a non-empty FIFO: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow: ovf_clr clears it. If ovf_clr and a drop occur in the same cycle, overflow stays set.
- Reset mid-frame or mid-FIFO: immediate return to the reset state; partial frame and queued events are discarded.
- The block never drives the PS/2 lines (receive only).

Test Plan:
- Make code 1C (data LSB first 0,0,1,1,1,0,0,0; parity 0; stop 1), ev_ready=1 -> one event code=1C, ext=0, break=0; ev_valid rises 2 cycles after the stop edge; no error pulses.
- Bytes F0,1C then E0,75 then E0,F0,75 -> three events: {1C,ext0,brk1}, {75,ext1,brk0}, {75,ext1,brk1}.
- Byte 1C sent with parity=1 -> single parity_err pulse, no event. A preceding E0 is discarded, so a following good 1C gives ext=0.
- Five bits of a frame, then ps2_clk held high for TIMEOUT_CYCLES -> frame_err exactly at the timeout, FSM back in IDLE; next good frame 29 decodes as code=29.
- FIFO_DEPTH=8, ev_ready=0, nine make codes 01..09 -> fifo_count=8, overflow=1. Draining yields 01..08 in order, then ev_valid=0. ovf_clr clears overflow.
- Reset asserted asynchronously mid-frame with 3 events queued -> all outputs 0 immediately, fifo_count=0; a following good frame decodes normally.
